// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// The tag-byte option is enabled with UART_TX_SCHED_TAG_EN.
package uart_tx_sched_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam logic [3:0]  TAG_NIBBLE = 4'hA;

    typedef enum logic [2:0] {
        IDLE,
        TAG_START,
        TAG_WAIT,
        START,
        WAIT
    } sched_state_t;

    function automatic logic [BYTE_W-1:0] make_tag(input logic [3:0] id);
        return {TAG_NIBBLE, id};
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester and transmitter handshake bundle for uart_tx_scheduler.
// slave = scheduler side, master = producers plus transmitter side.
interface uart_tx_scheduler_if #(
    parameter int unsigned NUM_REQ = 4
) ();
    import uart_tx_sched_pkg::*;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*BYTE_W-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;
    logic [NUM_REQ-1:0]        done;
    logic                      tx_start;
    logic [BYTE_W-1:0]         tx_data;
    logic                      tx_busy;

    modport master (
        output req, req_data, tx_busy,
        input  ack, done, tx_start, tx_data
    );

    modport slave (
        input  req, req_data, tx_busy,
        output ack, done, tx_start, tx_data
    );

endinterface

// File: rtl/uart_tx_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request above rr_ptr, with wrap.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               valid,
    output logic [ID_W-1:0]    index
);

    logic [NUM_REQ-1:0] rot;
    int unsigned        start;
    int unsigned        offset;
    int unsigned        sum;

    // Rotating the doubled vector puts lane rr_ptr+1 at bit 0.
    always_comb begin
        start  = 32'(rr_ptr) + 32'd1;
        rot    = NUM_REQ'({req, req} >> start);
        offset = 0;
        for (int unsigned i = NUM_REQ; i > 0; i--) begin
            if (rot[i-1]) begin
                offset = i - 1;
            end
        end
        sum = start + offset;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        valid = |req;
        index = ID_W'(sum);
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ producers.
// Define UART_TX_SCHED_TAG_EN to prefix each payload with {4'hA, grant_id}.
module uart_tx_scheduler
    import uart_tx_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_tx_scheduler_if.slave  bus,
    output logic                sched_busy,
    output logic [ID_W-1:0]     grant_id
);

    sched_state_t       state_q, state_n;
    logic               tx_start_q, tx_start_n;
    logic [BYTE_W-1:0]  tx_data_q, tx_data_n;
    logic [NUM_REQ-1:0] ack_q, ack_n;
    logic [NUM_REQ-1:0] done_q, done_n;
    logic [ID_W-1:0]    grant_q, grant_n;
    logic [ID_W-1:0]    rr_q, rr_n;
    logic               busy_q, busy_n;
`ifdef UART_TX_SCHED_TAG_EN
    logic [BYTE_W-1:0]  payload_q, payload_n;
`endif

    logic               pick_valid;
    logic [ID_W-1:0]    pick_idx;
    logic [BYTE_W-1:0]  pick_data;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req    (bus.req),
        .rr_ptr (rr_q),
        .valid  (pick_valid),
        .index  (pick_idx)
    );

    assign pick_data = bus.req_data[pick_idx*BYTE_W +: BYTE_W];

    always_comb begin
        state_n    = state_q;
        tx_start_n = tx_start_q;
        tx_data_n  = tx_data_q;
        ack_n      = '0;
        done_n     = '0;
        grant_n    = grant_q;
        rr_n       = rr_q;
`ifdef UART_TX_SCHED_TAG_EN
        payload_n  = payload_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_n    = pick_idx;
                    ack_n      = NUM_REQ'(1) << pick_idx;
                    tx_start_n = 1'b1;
`ifdef UART_TX_SCHED_TAG_EN
                    tx_data_n  = make_tag(4'(pick_idx));
                    payload_n  = pick_data;
                    state_n    = TAG_START;
`else
                    tx_data_n  = pick_data;
                    state_n    = START;
`endif
                end
            end
`ifdef UART_TX_SCHED_TAG_EN
            TAG_START: begin
                if (bus.tx_busy) begin
                    tx_start_n = 1'b0;
                    state_n    = TAG_WAIT;
                end
            end
            TAG_WAIT: begin
                if (!bus.tx_busy) begin
                    tx_data_n  = payload_q;
                    tx_start_n = 1'b1;
                    state_n    = START;
                end
            end
`endif
            START: begin
                if (bus.tx_busy) begin
                    tx_start_n = 1'b0;
                    state_n    = WAIT;
                end
            end
            WAIT: begin
                if (!bus.tx_busy) begin
                    done_n  = NUM_REQ'(1) << grant_q;
                    rr_n    = grant_q;
                    state_n = IDLE;
                end
            end
            default: begin
                tx_start_n = 1'b0;
                state_n    = IDLE;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            ack_q      <= '0;
            done_q     <= '0;
            grant_q    <= '0;
            rr_q       <= ID_W'(NUM_REQ - 1);
            busy_q     <= 1'b0;
`ifdef UART_TX_SCHED_TAG_EN
            payload_q  <= '0;
`endif
        end else begin
            state_q    <= state_n;
            tx_start_q <= tx_start_n;
            tx_data_q  <= tx_data_n;
            ack_q      <= ack_n;
            done_q     <= done_n;
            grant_q    <= grant_n;
            rr_q       <= rr_n;
            busy_q     <= busy_n;
`ifdef UART_TX_SCHED_TAG_EN
            payload_q  <= payload_n;
`endif
        end
    end

    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.ack      = ack_q;
    assign bus.done     = done_q;
    assign sched_busy   = busy_q;
    assign grant_id     = grant_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler; honours UART_TX_SCHED_TAG_EN.
module tb_uart_tx_scheduler;
    import uart_tx_sched_pkg::*;

    localparam int unsigned N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sched_busy;
    logic [1:0] grant_id;

    uart_tx_scheduler_if #(.NUM_REQ(N)) bus ();

    uart_tx_scheduler #(
        .NUM_REQ (N),
        .ID_W    (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .sched_busy (sched_busy),
        .grant_id   (grant_id)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;

    // Transmitter model: accepts a byte on tx_start, stays busy 3 cycles.
    logic        model_en = 1'b0;
    logic        busy_man = 1'b0;
    logic        m_busy = 1'b0;
    int          m_cnt = 0;
    logic        prev_start = 1'b0;
    int          overlap = 0;
    logic [7:0]  sent[$];

    assign bus.tx_busy = model_en ? m_busy : busy_man;

    always @(posedge clk) begin
        if (!model_en) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
        end else if (m_busy) begin
            if (m_cnt == 0) m_busy <= 1'b0;
            else            m_cnt  <= m_cnt - 1;
        end else if (bus.tx_start) begin
            m_busy <= 1'b1;
            m_cnt  <= 2;
            sent.push_back(bus.tx_data);
        end
        if (model_en && bus.tx_start && !prev_start && bus.tx_busy) overlap <= overlap + 1;
        prev_start <= bus.tx_start;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct packed {
        logic [3:0]  req;
        logic [31:0] data;
        logic        busy;
        logic [3:0]  ack;
        logic [3:0]  done;
        logic        start;
        logic [7:0]  txd;
        logic        sb;
        logic [1:0]  gid;
    } vec_t;

    vec_t        vecs[$];
    logic [7:0]  exp_q[$];
    int          grants[$];
    int          done_at[$];
    int          done_cnt[N];
    int unsigned seq_base;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    function automatic void add(input logic [3:0] r, input logic [31:0] d, input logic b,
                                input logic [3:0] a, input logic [3:0] dn, input logic s,
                                input logic [7:0] t, input logic sb, input logic [1:0] g);
        vec_t v;
        v.req = r; v.data = d; v.busy = b; v.ack = a; v.done = dn;
        v.start = s; v.txd = t; v.sb = sb; v.gid = g;
        vecs.push_back(v);
    endfunction

    function automatic void add_exp(input int unsigned lane, input logic [7:0] d);
`ifdef UART_TX_SCHED_TAG_EN
        exp_q.push_back({TAG_NIBBLE, 4'(lane)});
`endif
        exp_q.push_back(d);
    endfunction

    task automatic start_seq();
        exp_q.delete();
        grants.delete();
        done_at.delete();
        for (int i = 0; i < N; i++) done_cnt[i] = 0;
        seq_base = sent.size();
    endtask

    task automatic do_reset();
        model_en = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        rst_n    = 1'b1;
        model_en = 1'b1;
    endtask

    // Runs until n_done done pulses; drops each lane's req after its ack unless kept.
    task automatic run_seq(input int unsigned n_done, input logic [3:0] keep,
                           input bit chg, input int unsigned budget);
        int unsigned got = 0;
        for (int unsigned c = 0; c < budget && got < n_done; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (bus.ack[i]) begin
                    grants.push_back(i);
                    if (chg) bus.req_data = '1;
                end
                if (bus.done[i]) begin
                    done_cnt[i]++;
                    got++;
                    done_at.push_back(int'(sent.size() - seq_base));
                end
            end
            bus.req = bus.req & (~bus.ack | keep);
        end
        checks++;
        if (got < n_done) begin
            errors++;
            $display("FAIL timeout: %0d done pulses, expected %0d", got, n_done);
        end
    endtask

    task automatic check_sent(input string name);
        check({name, " len"}, sent.size() - seq_base, exp_q.size());
        for (int unsigned i = 0; i < exp_q.size() && seq_base + i < sent.size(); i++)
            check($sformatf("%s byte%0d", name, i), {24'h0, sent[seq_base+i]}, {24'h0, exp_q[i]});
    endtask

    task automatic check_grants(input string name, input int e0, input int e1, input int e2, input int e3);
        int e[4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        check({name, " count"}, grants.size(), 4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            check($sformatf("%s grant%0d", name, i), grants[i], e[i]);
    endtask

    initial begin
        bus.req      = '0;
        bus.req_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset ack", bus.ack, 0);
        check("reset done", bus.done, 0);
        check("reset tx_start", bus.tx_start, 0);
        check("reset tx_data", bus.tx_data, 0);
        check("reset sched_busy", sched_busy, 0);
        check("reset grant_id", grant_id, 0);
        rst_n = 1'b1;

        // req, data, busy | ack, done, start, tx_data, sched_busy, grant_id
`ifdef UART_TX_SCHED_TAG_EN
        add(4'b0100, 32'h005A0000, 1'b0, 4'b0100, 4'b0000, 1'b1, 8'hA2, 1'b1, 2'd2);
        add(4'b0000, 32'h00FF0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 8'hA2, 1'b1, 2'd2);
        add(4'b0000, 32'h00FF0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'hA2, 1'b1, 2'd2);
        add(4'b0000, 32'h00000000, 1'b0, 4'b0000, 4'b0000, 1'b1, 8'h5A, 1'b1, 2'd2);
        add(4'b0000, 32'h00000000, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h5A, 1'b1, 2'd2);
        add(4'b0000, 32'h00000000, 1'b0, 4'b0000, 4'b0100, 1'b0, 8'h5A, 1'b0, 2'd2);
        add(4'b0000, 32'h00000000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h5A, 1'b0, 2'd2);
`else
        add(4'b0100, 32'h005A0000, 1'b0, 4'b0100, 4'b0000, 1'b1, 8'h5A, 1'b1, 2'd2);
        add(4'b0000, 32'h00FF0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 8'h5A, 1'b1, 2'd2);
        add(4'b0000, 32'h00FF0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h5A, 1'b1, 2'd2);
        add(4'b0000, 32'h00000000, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h5A, 1'b1, 2'd2);
        add(4'b0000, 32'h00000000, 1'b0, 4'b0000, 4'b0100, 1'b0, 8'h5A, 1'b0, 2'd2);
        add(4'b0000, 32'h00000000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h5A, 1'b0, 2'd2);
        add(4'b0001, 32'h0000003C, 1'b1, 4'b0001, 4'b0000, 1'b1, 8'h3C, 1'b1, 2'd0);
        add(4'b0000, 32'h00000000, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h3C, 1'b1, 2'd0);
        add(4'b1000, 32'h77000000, 1'b0, 4'b0000, 4'b0001, 1'b0, 8'h3C, 1'b0, 2'd0);
        add(4'b1000, 32'h77000000, 1'b0, 4'b1000, 4'b0000, 1'b1, 8'h77, 1'b1, 2'd3);
        add(4'b0000, 32'h00000000, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h77, 1'b1, 2'd3);
        add(4'b0000, 32'h00000000, 1'b0, 4'b0000, 4'b1000, 1'b0, 8'h77, 1'b0, 2'd3);
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            bus.req      = vecs[i].req;
            bus.req_data = vecs[i].data;
            busy_man     = vecs[i].busy;
            @(posedge clk); #1;
            check($sformatf("vec%0d ack", i), bus.ack, vecs[i].ack);
            check($sformatf("vec%0d done", i), bus.done, vecs[i].done);
            check($sformatf("vec%0d tx_start", i), bus.tx_start, vecs[i].start);
            check($sformatf("vec%0d tx_data", i), bus.tx_data, vecs[i].txd);
            check($sformatf("vec%0d sched_busy", i), sched_busy, vecs[i].sb);
            check($sformatf("vec%0d grant_id", i), grant_id, vecs[i].gid);
        end
        busy_man     = 1'b0;
        bus.req      = '0;
        bus.req_data = '0;

        // Single request on lane 1; done must follow the last byte of the lane.
        do_reset();
        start_seq();
        add_exp(1, 8'hC3);
        bus.req_data = 32'h0000C300;
        bus.req      = 4'b0010;
        run_seq(1, 4'b0000, 1'b0, 60);
        check_sent("single");
        check("single done[1]", done_cnt[1], 1);
        check("single done_at count", done_at.size(), 1);
        if (done_at.size() > 0) check("single done after bytes", done_at[0], exp_q.size());
        check("single grant_id", grant_id, 1);

        // All lanes at once: strict rotation 0,1,2,3.
        do_reset();
        start_seq();
        add_exp(0, 8'h11); add_exp(1, 8'h22); add_exp(2, 8'h33); add_exp(3, 8'h44);
        bus.req_data = 32'h44332211;
        bus.req      = 4'b1111;
        run_seq(4, 4'b0000, 1'b0, 200);
        check_sent("all4");
        check_grants("all4", 0, 1, 2, 3);
        for (int i = 0; i < N; i++) check($sformatf("all4 done[%0d]", i), done_cnt[i], 1);

        // Lane 0 holds req; lane 3 must still get its turn.
        do_reset();
        start_seq();
        add_exp(0, 8'hD0); add_exp(3, 8'hE3); add_exp(0, 8'hD0); add_exp(0, 8'hD0);
        bus.req_data = 32'hE30000D0;
        bus.req      = 4'b1001;
        run_seq(4, 4'b0001, 1'b0, 300);
        bus.req = '0;
        check_sent("fair");
        check_grants("fair", 0, 3, 0, 0);

        // req_data changed after ack must not reach the transmitter.
        do_reset();
        start_seq();
        add_exp(2, 8'h5A);
        bus.req_data = 32'h005A0000;
        bus.req      = 4'b0100;
        run_seq(1, 4'b0000, 1'b1, 60);
        check_sent("datachg");

        // Reset while waiting on tx_busy, after lane 0 moved the pointer.
        start_seq();
        bus.req_data = 32'h00000001;
        bus.req      = 4'b0001;
        run_seq(1, 4'b0000, 1'b0, 60);
        bus.req_data = 32'h005A0000;
        bus.req      = 4'b0100;
        begin
            bit hit = 1'b0;
            for (int c = 0; c < 60 && !hit; c++) begin
                @(posedge clk); #1;
                bus.req = bus.req & ~bus.ack;
                if (sched_busy && !bus.tx_start && bus.tx_busy) hit = 1'b1;
            end
            check("midrst reached wait", hit, 1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("midrst tx_start", bus.tx_start, 0);
        check("midrst ack", bus.ack, 0);
        check("midrst done", bus.done, 0);
        check("midrst sched_busy", sched_busy, 0);
        check("midrst grant_id", grant_id, 0);
        model_en = 1'b0;
        @(posedge clk); #1;
        rst_n    = 1'b1;
        model_en = 1'b1;
        start_seq();
        bus.req_data = 32'h00660077;
        bus.req      = 4'b0101;
        run_seq(2, 4'b0000, 1'b0, 120);
        check("midrst grants", grants.size(), 2);
        if (grants.size() > 1) begin
            check("midrst first grant", grants[0], 0);
            check("midrst second grant", grants[1], 2);
        end

        check("tx_start overlap", overlap, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
